// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: producer side of the INST / ALU_out interface.
// Tagged requests are queued in a small FIFO and issued one at a time as a
// registered instruction to a combinational ALU. ALU_out is sampled after
// ALU_LAT cycles, and the result is returned with its tag over a valid/ready
// port. DIV-by-zero and illegal opcodes are screened here. For those cases
// the ALU output is ignored and the result is all ones with res_err set.
//
// Instruction word layout (INST): {opc[2:0], op_a[DATA_W-1:0], op_b[DATA_W-1:0]}
// Result width (ALU_out, res_data): 2*DATA_W
// Opcodes: ADD=0, SUB=1, MUL=2, DIV=3, VAR=4; encodings 5..7 are illegal.
module alu_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   in_opc,
    input  logic [DATA_W-1:0]            in_op_a,
    input  logic [DATA_W-1:0]            in_op_b,
    input  logic [TAG_W-1:0]             in_tag,
    output logic [2*DATA_W+2:0]          INST,
    input  logic [2*DATA_W-1:0]          ALU_out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [2*DATA_W-1:0]          res_data,
    output logic [TAG_W-1:0]             res_tag,
    output logic                         res_err,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int OPC_W  = 3;
    localparam int INST_W = OPC_W + 2 * DATA_W;
    localparam int RES_W  = 2 * DATA_W;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int LAT_W  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [OPC_W-1:0] OPC_ADD = 3'd0;
    localparam logic [OPC_W-1:0] OPC_SUB = 3'd1;
    localparam logic [OPC_W-1:0] OPC_MUL = 3'd2;
    localparam logic [OPC_W-1:0] OPC_DIV = 3'd3;
    localparam logic [OPC_W-1:0] OPC_VAR = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // The request must not go to the ALU as a normal result if it is
    // a division by zero or uses an opcode the ALU does not define.
    function automatic logic screen_bad(input logic [OPC_W-1:0] opc,
                                        input logic [DATA_W-1:0] op_b);
        logic legal;
        legal = (opc == OPC_ADD) || (opc == OPC_SUB) || (opc == OPC_MUL) ||
                (opc == OPC_DIV) || (opc == OPC_VAR);
        return !legal || ((opc == OPC_DIV) && (op_b == '0));
    endfunction

    // Request FIFO storage (data only, never reset)
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [TAG_W-1:0]  tag_mem  [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;

    state_t            state_q;
    state_t            state_d;
    logic [LAT_W-1:0]  lat_cnt;
    logic [TAG_W-1:0]  tag_p0;

    logic              push;
    logic              pop;
    logic              sample;
    logic              accept;
    logic              exec_bad;
    logic [OPC_W-1:0]  exec_opc;
    logic [DATA_W-1:0] exec_op_b;

    // The full flag comes from the registered count only, so a pop on the
    // same edge does not open a slot early.
    assign in_ready   = (count_q < CNT_W'(DEPTH));
    assign push       = in_valid && in_ready;
    assign fifo_count = count_q;

    assign exec_opc   = INST[INST_W-1 -: OPC_W];
    assign exec_op_b  = INST[DATA_W-1:0];
    assign exec_bad   = screen_bad(exec_opc, exec_op_b);

    // Write the incoming request into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= {in_opc, in_op_a, in_op_b};
            tag_mem[wr_ptr]  <= in_tag;
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the per-edge strobes: pop (issue), sample (capture ALU), accept (result taken)
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        sample  = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (lat_cnt == LAT_W'(ALU_LAT - 1)) begin
                    sample  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (res_ready) begin
                    accept  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Settle counter: cleared when an instruction is issued, then counts while it is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt <= '0;
        end else if (pop) begin
            lat_cnt <= '0;
        end else if (state_q == EXEC) begin
            lat_cnt <= lat_cnt + LAT_W'(1);
        end
    end

    // Issue register and result port. INST keeps the last issued instruction after it completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            INST      <= '0;
            tag_p0    <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_tag   <= '0;
            res_err   <= 1'b0;
        end else begin
            if (pop) begin
                INST   <= inst_mem[rd_ptr];
                tag_p0 <= tag_mem[rd_ptr];
            end
            if (sample) begin
                res_valid <= 1'b1;
                res_tag   <= tag_p0;
                if (exec_bad) begin
                    res_data <= {RES_W{1'b1}};
                    res_err  <= 1'b1;
                end else begin
                    res_data <= ALU_out;
                    res_err  <= 1'b0;
                end
            end else if (accept) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule
